// File: rtl/cla_adder_scheduler_if.sv
// Handshake bundle between two wide-add requesters, one result consumer
// and the shared carry-lookahead scheduler.
interface cla_adder_scheduler_if #(
    parameter int unsigned WIDTH = 64
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        output res_ready,
        input  res_valid, res_id, res_sum, res_cout
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        input  res_ready,
        output res_valid, res_id, res_sum, res_cout
    );
endinterface

// File: rtl/cla_adder_scheduler.sv
// Time-shared wide adder: two requesters take turns on one SEG-bit two-level
// carry-lookahead slice, one segment per cycle, least significant first.
module cla_adder_scheduler #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SEG   = 16
) (
    input logic                  Clk,
    input logic                  Rst,
    cla_adder_scheduler_if.slave bus
);
    localparam int unsigned NSEG = WIDTH / SEG;
    localparam int unsigned CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int unsigned GRP  = 4;
    localparam int unsigned NGRP = SEG / GRP;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             last_grant;

    logic             grant_valid_c;
    logic             grant_id_c;
    logic [SEG-1:0]   a_seg_c;
    logic [SEG-1:0]   b_seg_c;
    logic [SEG-1:0]   gen_c;
    logic [SEG-1:0]   prop_c;
    logic [NGRP-1:0]  grp_g_c;
    logic [NGRP-1:0]  grp_p_c;
    logic [NGRP:0]    grp_c_c;
    logic [SEG-1:0]   seg_sum_c;
    logic             seg_cout_c;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        grant_valid_c = 1'b0;
        grant_id_c    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_valid_c = 1'b1;
            grant_id_c    = ~last_grant;
        end else if (bus.req0_valid) begin
            grant_valid_c = 1'b1;
        end else if (bus.req1_valid) begin
            grant_valid_c = 1'b1;
            grant_id_c    = 1'b1;
        end
    end

    // Ready is offered only in IDLE and is forced low while reset is held.
    assign bus.req0_ready = Rst && (state == IDLE) && grant_valid_c && !grant_id_c;
    assign bus.req1_ready = Rst && (state == IDLE) && grant_valid_c &&  grant_id_c;

    // Select the operand segment currently being summed.
    always_comb begin
        a_seg_c = '0;
        b_seg_c = '0;
        for (int unsigned k = 0; k < NSEG; k++) begin
            if (cnt == CW'(k)) begin
                a_seg_c = a_q[k*SEG +: SEG];
                b_seg_c = b_q[k*SEG +: SEG];
            end
        end
    end

    // Two-level CLA: 4-bit group generate/propagate, then group carries.
    always_comb begin
        logic gg;
        logic pp;
        logic bc;
        gg        = 1'b0;
        pp        = 1'b1;
        bc        = 1'b0;
        gen_c     = a_seg_c & b_seg_c;
        prop_c    = a_seg_c ^ b_seg_c;
        grp_g_c   = '0;
        grp_p_c   = '0;
        grp_c_c   = '0;
        seg_sum_c = '0;
        for (int unsigned j = 0; j < NGRP; j++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int unsigned i = 0; i < GRP; i++) begin
                gg = gen_c[j*GRP+i] | (prop_c[j*GRP+i] & gg);
                pp = pp & prop_c[j*GRP+i];
            end
            grp_g_c[j] = gg;
            grp_p_c[j] = pp;
        end
        grp_c_c[0] = carry;
        for (int unsigned j = 0; j < NGRP; j++) begin
            grp_c_c[j+1] = grp_g_c[j] | (grp_p_c[j] & grp_c_c[j]);
        end
        for (int unsigned j = 0; j < NGRP; j++) begin
            bc = grp_c_c[j];
            for (int unsigned i = 0; i < GRP; i++) begin
                seg_sum_c[j*GRP+i] = prop_c[j*GRP+i] ^ bc;
                bc = gen_c[j*GRP+i] | (prop_c[j*GRP+i] & bc);
            end
        end
        seg_cout_c = grp_c_c[NGRP];
    end

    // Sequencer: accept in IDLE, one segment per cycle in ADD, hold in DONE.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            cnt           <= '0;
            carry         <= 1'b0;
            last_grant    <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_id    <= 1'b0;
            bus.res_sum   <= '0;
            bus.res_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid_c) begin
                        a_q        <= grant_id_c ? bus.req1_a   : bus.req0_a;
                        b_q        <= grant_id_c ? bus.req1_b   : bus.req0_b;
                        carry      <= grant_id_c ? bus.req1_cin : bus.req0_cin;
                        bus.res_id <= grant_id_c;
                        last_grant <= grant_id_c;
                        cnt        <= '0;
                        state      <= ADD;
                    end
                end
                ADD: begin
                    for (int unsigned k = 0; k < NSEG; k++) begin
                        if (cnt == CW'(k)) begin
                            bus.res_sum[k*SEG +: SEG] <= seg_sum_c;
                        end
                    end
                    carry <= seg_cout_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(NSEG - 1)) begin
                        bus.res_cout  <= seg_cout_c;
                        bus.res_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_adder_scheduler.sv
// Directed and table-driven checks for the shared segmented CLA scheduler.
module tb_cla_adder_scheduler;
    localparam int unsigned W = 64;

    typedef struct {
        bit          id;
        logic [63:0] a;
        logic [63:0] b;
        bit          cin;
        logic [63:0] sum;
        bit          cout;
        int          stall;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   viol = 0;
    vec_t vecs[8];

    cla_adder_scheduler_if #(.WIDTH(W)) bus ();

    cla_adder_scheduler #(.WIDTH(W), .SEG(16)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.req0_ready && bus.req1_ready) viol++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_req(input bit id, input bit v, input logic [63:0] a,
                           input logic [63:0] b, input bit cin);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
        end
    endtask

    // Starts at a falling edge; returns the granted id or -1 on timeout.
    task automatic wait_grant(output int gid);
        gid = -1;
        for (int t = 0; t < 30; t++) begin
            #1;
            if (bus.req0_ready) begin gid = 0; break; end
            if (bus.req1_ready) begin gid = 1; break; end
            @(negedge clk);
        end
        if (gid < 0) chk("grant_timeout", 1, 0);
    endtask

    // Starts just after the accept edge; counts edges until res_valid.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) begin lat = c; break; end
        end
    endtask

    task automatic collect(input bit id, input logic [63:0] sum, input bit cout,
                           input int stall, input string tag);
        int lat;
        wait_valid(lat);
        chk({tag, "_latency"}, lat, 4);
        if (lat != 0) begin
            chk({tag, "_sum"}, bus.res_sum, sum);
            chk({tag, "_cout"}, bus.res_cout, cout);
            chk({tag, "_id"}, bus.res_id, id);
        end
        repeat (stall) @(negedge clk);
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic run_op(input bit id, input logic [63:0] a, input logic [63:0] b,
                          input bit cin, input logic [63:0] sum, input bit cout,
                          input int stall, input string tag);
        int g;
        @(negedge clk);
        set_req(id, 1'b1, a, b, cin);
        wait_grant(g);
        chk({tag, "_grant"}, g, id);
        @(posedge clk);
        #1;
        set_req(id, 1'b0, a, b, cin);
        collect(id, sum, cout, stall, tag);
    endtask

    initial begin
        int          g;
        int          lat;
        logic [64:0] r;
        logic [63:0] ra;
        logic [63:0] rb;
        bit          rid;
        bit          rcin;

        vecs[0] = '{1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 0};
        vecs[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1};
        vecs[2] = '{1'b0, 64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 0};
        vecs[3] = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 2};
        vecs[4] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 0};
        vecs[5] = '{1'b1, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b1, 64'h0, 1'b1, 3};
        vecs[6] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0};
        vecs[7] = '{1'b1, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1};

        set_req(1'b0, 1'b1, 64'h5, 64'h6, 1'b0);
        set_req(1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state",
            {bus.res_valid, bus.res_id, bus.res_cout, bus.res_sum, bus.req0_ready, bus.req1_ready},
            69'h0);
        set_req(1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].sum, vecs[i].cout, vecs[i].stall, $sformatf("vec%0d", i));
        end

        // Both valid continuously: grants must alternate starting with 0.
        @(negedge clk);
        set_req(1'b0, 1'b1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
        set_req(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            chk($sformatf("alt_grant%0d", k), g, k % 2);
            @(posedge clk);
            if (g == 1) collect(1'b1, 64'h1, 1'b1, 0, "alt1");
            else        collect(1'b0, 64'h3333_3333_3333_3333, 1'b0, 0, "alt0");
        end
        set_req(1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        set_req(1'b1, 1'b0, 64'h0, 64'h0, 1'b0);

        // Result stall with a competing request waiting.
        @(negedge clk);
        set_req(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
        wait_grant(g);
        chk("stall_grant", g, 0);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
        set_req(1'b1, 1'b1, 64'h1, 64'h2, 1'b1);
        wait_valid(lat);
        chk("stall_latency", lat, 4);
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            #1;
            chk("stall_hold",
                {bus.res_valid, bus.res_id, bus.res_cout, bus.res_sum, bus.req0_ready, bus.req1_ready},
                {1'b1, 1'b0, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0});
        end
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_release_valid", bus.res_valid, 0);
        chk("stall_next_grant", bus.req1_ready, 1);
        @(negedge clk);
        bus.res_ready = 1'b0;
        @(posedge clk);
        #1;
        set_req(1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
        collect(1'b1, 64'h4, 1'b0, 0, "stall_next");

        // Asynchronous reset while segment 2 is in flight.
        @(negedge clk);
        set_req(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
        wait_grant(g);
        chk("rst_grant", g, 1);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_clear",
            {bus.res_valid, bus.res_id, bus.res_cout, bus.res_sum, bus.req0_ready, bus.req1_ready},
            69'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_grant(g);
        chk("rst_regrant", g, 1);
        @(posedge clk);
        #1;
        set_req(1'b1, 1'b0, 64'h0, 64'h0, 1'b0);
        collect(1'b1, 64'h2222_2222_2222_2212, 1'b0, 1, "rst_retry");

        // Random operands on both ports against a 65-bit reference sum.
        for (int n = 0; n < 1000; n++) begin
            rid  = 1'($urandom_range(0, 1));
            rcin = 1'($urandom_range(0, 1));
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            r    = {1'b0, ra} + {1'b0, rb} + 65'(rcin);
            run_op(rid, ra, rb, rcin, r[63:0], r[64], int'($urandom_range(0, 3)), "rand");
        end

        chk("ready_exclusive", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
